// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: pipeline store/load side plus the mem_control write port.
// The slave modport belongs to the buffer; the master modport drives the buffer's inputs.
interface store_buffer_if;
  // Pipeline store port
  logic        st_valid_i;
  logic        st_ready_o;
  logic [1:0]  st_acc_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic        st_misalign_o;
  // Pipeline load hazard port
  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic        ld_stall_o;
  // mem_control write port
  logic        wr_en_o;
  logic [1:0]  acc_w_o;
  logic [31:0] addr_w_o;
  logic [31:0] data_w_o;
  logic        wr_ready_i;
  // Fence support
  logic        empty_o;

  modport slave (
    input  st_valid_i, st_acc_i, st_addr_i, st_data_i, ld_valid_i, ld_addr_i, wr_ready_i,
    output st_ready_o, st_misalign_o, ld_stall_o, wr_en_o, acc_w_o, addr_w_o, data_w_o, empty_o
  );

  modport master (
    output st_valid_i, st_acc_i, st_addr_i, st_data_i, ld_valid_i, ld_addr_i, wr_ready_i,
    input  st_ready_o, st_misalign_o, ld_stall_o, wr_en_o, acc_w_o, addr_w_o, data_w_o, empty_o
  );
endinterface

// File: rtl/store_buffer.sv
// Store queue between the load/store stage and mem_control. Accepts one store per cycle,
// drains in FIFO order through a two-cycle issue/commit handshake, and stalls loads that
// overlap a pending store word or that collide with a write occupying the memory port.
// Optional feature macro: STBUF_LOAD_PRIORITY_EN (loads get the memory port first).
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk_i,
  input logic           rstn_i,
  store_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  localparam logic [1:0] MemAccessByte     = 2'b00;
  localparam logic [1:0] MemAccessHalfword = 2'b01;
  localparam logic [1:0] MemAccessWord     = 2'b10;

  typedef enum logic {StIdle, StCommit} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            misalign_q, misalign_d;

  logic [1:0]  acc_mem  [DEPTH];
  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic             aligned;
  logic             push;
  logic             pop;
  logic             issue;
  logic             hit;
  logic             busy;
  logic             drain_ok;
  logic [DEPTH-1:0] entry_valid;

  // Only the word index of a load matters for the overlap check.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^bus.ld_addr_i[1:0];

  // Natural-alignment check on the incoming store.
  always_comb begin
    aligned = 1'b1;
    case (bus.st_acc_i)
      MemAccessHalfword: aligned = ~bus.st_addr_i[0];
      MemAccessWord:     aligned = (bus.st_addr_i[1:0] == 2'b00);
      default:           aligned = 1'b1;
    endcase
  end

  assign bus.st_ready_o = (count_q != Full);
  assign push           = bus.st_valid_i & bus.st_ready_o & aligned;

  // An entry is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PtrW'(i) - rd_ptr_q}) < count_q;
    end
  end

  // Word-granular overlap of the load against every live entry, head included.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (addr_mem[i][31:2] == bus.ld_addr_i[31:2])) begin
        hit = 1'b1;
      end
    end
    hit = hit & bus.ld_valid_i;
  end

`ifdef STBUF_LOAD_PRIORITY_EN
  // Yield the port to a load unless it is blocked by a hit anyway or the queue is full.
  assign drain_ok = ~bus.ld_valid_i | hit | (count_q == Full);
`else
  assign drain_ok = 1'b1;
`endif

  // Issue/commit sequencing towards mem_control.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && bus.wr_ready_i && drain_ok) begin
          issue   = 1'b1;
          state_d = StCommit;
        end
      end
      StCommit: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write port shows the head entry whenever one exists; zero when empty.
  always_comb begin
    bus.wr_en_o  = issue;
    bus.acc_w_o  = '0;
    bus.addr_w_o = '0;
    bus.data_w_o = '0;
    if (count_q != '0) begin
      bus.acc_w_o  = acc_mem[rd_ptr_q];
      bus.addr_w_o = addr_mem[rd_ptr_q];
      bus.data_w_o = data_mem[rd_ptr_q];
    end
  end

  assign busy           = (state_q == StCommit) | (issue & bus.wr_ready_i);
  assign bus.ld_stall_o = bus.ld_valid_i & (hit | busy);
  assign bus.empty_o    = (count_q == '0) && (state_q == StIdle);
  assign bus.st_misalign_o = misalign_q;

  // Pointer, occupancy and misalign-pulse next state.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    misalign_d = bus.st_valid_i & bus.st_ready_o & ~aligned;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage; contents are only observed through live entries, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      acc_mem[wr_ptr_q]  <= bus.st_acc_i;
      addr_mem[wr_ptr_q] <= bus.st_addr_i;
      data_mem[wr_ptr_q] <= bus.st_data_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a scoreboard queue holds every accepted store and
// is drained in order by a write-port monitor; scenario tasks check timing inline.
module tb_store_buffer;

  localparam logic [1:0] AccByte = 2'b00;
  localparam logic [1:0] AccHalf = 2'b01;
  localparam logic [1:0] AccWord = 2'b10;

  typedef struct packed {
    logic [1:0]  acc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  store_buffer_if bus();

  store_buffer #(.DEPTH(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  wr_t         exp_q[$];
  int          issue_cyc[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every issued write must match the oldest accepted store.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.wr_en_o === 1'b1) begin
        issue_cyc.push_back(cyc);
        mem[bus.addr_w_o] = bus.data_w_o;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got addr %h data %h, want no write",
                   bus.addr_w_o, bus.data_w_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.acc_w_o !== e.acc || bus.addr_w_o !== e.addr || bus.data_w_o !== e.data) begin
            errors++;
            $display("FAIL sb_write: got acc %0d addr %h data %h, want acc %0d addr %h data %h",
                     bus.acc_w_o, bus.addr_w_o, bus.data_w_o, e.acc, e.addr, e.data);
          end
        end
      end
    end
  endtask

  // Presents one store for a single edge; expects room in the buffer.
  task automatic send_store(input logic [1:0] acc, input logic [31:0] addr,
                            input logic [31:0] data);
    logic ok;
    bus.st_valid_i = 1'b1;
    bus.st_acc_i   = acc;
    bus.st_addr_i  = addr;
    bus.st_data_i  = data;
    #1;
    checks++;
    if (bus.st_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_st_ready: got %b want 1 (addr %h)", bus.st_ready_o, addr);
    end
    ok = (acc == AccHalf) ? (addr[0] == 1'b0) :
         (acc == AccWord) ? (addr[1:0] == 2'b00) : 1'b1;
    if (ok) exp_q.push_back('{acc: acc, addr: addr, data: data});
    step();
    bus.st_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 32'h0;
    #2;
    checks++;
    if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b want 1", bus.st_ready_o); end
    checks++;
    if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty_o); end
    checks++;
    if (bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en_o); end
    checks++;
    if (bus.ld_stall_o !== 1'b0) begin errors++; $display("FAIL reset_ld_stall: got %b want 0", bus.ld_stall_o); end
    checks++;
    if (bus.st_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", bus.st_misalign_o); end
    checks++;
    if ({bus.acc_w_o, bus.addr_w_o, bus.data_w_o} !== 66'h0) begin
      errors++;
      $display("FAIL reset_w_outputs: got acc %0d addr %h data %h want 0", bus.acc_w_o, bus.addr_w_o, bus.data_w_o);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic test_single();
    bus.wr_ready_i = 1'b1;
    send_store(AccWord, 32'h1000, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b1 || bus.addr_w_o !== 32'h1000 || bus.data_w_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_issue: got wr_en %b addr %h data %h want 1 00001000 deadbeef",
               bus.wr_en_o, bus.addr_w_o, bus.data_w_o);
    end
    step();
    checks++;
    if (bus.wr_en_o !== 1'b0 || bus.addr_w_o !== 32'h1000 || bus.data_w_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_commit: got wr_en %b addr %h data %h want 0 00001000 deadbeef",
               bus.wr_en_o, bus.addr_w_o, bus.data_w_o);
    end
    checks++;
    if (bus.empty_o !== 1'b0) begin errors++; $display("FAIL single_empty_commit: got %b want 0", bus.empty_o); end
    step();
    checks++;
    if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b want 1", bus.empty_o); end
    checks++;
    if (!mem.exists(32'h1000) || mem[32'h1000] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_mem: got %h want deadbeef", mem.exists(32'h1000) ? mem[32'h1000] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  accs [3];
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    accs  = '{AccByte, AccHalf, AccWord};
    addrs = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0308};
    datas = '{32'h0000_0011, 32'h0000_BEEF, 32'h1234_5678};
    bus.wr_ready_i = 1'b1;
    issue_cyc.delete();
    for (int i = 0; i < 3; i++) send_store(accs[i], addrs[i], datas[i]);
    repeat (8) step();
    checks++;
    if (issue_cyc.size() != 3) begin errors++; $display("FAIL b2b_issues: got %0d want 3", issue_cyc.size()); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drained: got %0d left want 0", exp_q.size()); end
    checks++;
    if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", bus.empty_o); end
  endtask

  task automatic test_full_wrap();
    int base;
    bus.wr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_store(AccWord, 32'(i * 4), 32'hA0 + 32'(i));
    #1;
    checks++;
    if (bus.st_ready_o !== 1'b0) begin errors++; $display("FAIL full_st_ready: got %b want 0", bus.st_ready_o); end
    checks++;
    if (bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL full_no_issue: got %b want 0", bus.wr_en_o); end
    issue_cyc.delete();
    bus.wr_ready_i = 1'b1;
    bus.st_valid_i = 1'b1;
    bus.st_acc_i   = AccWord;
    bus.st_addr_i  = 32'h10;
    bus.st_data_i  = 32'hA4;
    base = cyc;
    #1;
    checks++;
    if (bus.st_ready_o !== 1'b0) begin errors++; $display("FAIL wrap_ready_c0: got %b want 0", bus.st_ready_o); end
    step();
    checks++;
    if (bus.st_ready_o !== 1'b0) begin errors++; $display("FAIL wrap_ready_c1: got %b want 0", bus.st_ready_o); end
    step();
    checks++;
    if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_ready_c2: got %b want 1", bus.st_ready_o); end
    exp_q.push_back('{acc: AccWord, addr: 32'h10, data: 32'hA4});
    step();
    bus.st_valid_i = 1'b0;
    repeat (8) step();
    checks++;
    if (issue_cyc.size() != 5) begin
      errors++;
      $display("FAIL wrap_issue_count: got %0d want 5", issue_cyc.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (issue_cyc[k] - base != 2 * k) begin
          errors++;
          $display("FAIL wrap_issue_cycle%0d: got %0d want %0d", k, issue_cyc[k] - base, 2 * k);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drained: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_load_hazard();
    bus.wr_ready_i = 1'b0;
    send_store(AccByte, 32'h2003, 32'h5A);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 32'h2000;
    #1;
    checks++;
    if (bus.ld_stall_o !== 1'b1) begin errors++; $display("FAIL hazard_hit: got %b want 1", bus.ld_stall_o); end
    bus.ld_addr_i = 32'h2004;
    #1;
    checks++;
    if (bus.ld_stall_o !== 1'b0) begin errors++; $display("FAIL hazard_miss: got %b want 0", bus.ld_stall_o); end
    bus.ld_addr_i  = 32'h2000;
    bus.wr_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b1 || bus.ld_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL hazard_issue: got wr_en %b stall %b want 1 1", bus.wr_en_o, bus.ld_stall_o);
    end
    step();
    bus.ld_addr_i = 32'h2004;
    #1;
    checks++;
    if (bus.ld_stall_o !== 1'b1) begin errors++; $display("FAIL hazard_commit_busy: got %b want 1", bus.ld_stall_o); end
    step();
    bus.ld_addr_i = 32'h2000;
    #1;
    checks++;
    if (bus.ld_stall_o !== 1'b0 || bus.empty_o !== 1'b1) begin
      errors++;
      $display("FAIL hazard_release: got stall %b empty %b want 0 1", bus.ld_stall_o, bus.empty_o);
    end
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic test_misalign();
    logic [1:0]  accs [2];
    logic [31:0] addrs [2];
    accs  = '{AccHalf, AccWord};
    addrs = '{32'h3001, 32'h3002};
    bus.wr_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_store(accs[i], addrs[i], 32'hCAFE);
      #1;
      checks++;
      if (bus.st_misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_pulse%0d: got %b want 1", i, bus.st_misalign_o); end
      checks++;
      if (bus.wr_en_o !== 1'b0 || bus.empty_o !== 1'b1) begin
        errors++;
        $display("FAIL misalign_dropped%0d: got wr_en %b empty %b want 0 1", i, bus.wr_en_o, bus.empty_o);
      end
      step();
      checks++;
      if (bus.st_misalign_o !== 1'b0 || bus.wr_en_o !== 1'b0) begin
        errors++;
        $display("FAIL misalign_end%0d: got misalign %b wr_en %b want 0 0", i, bus.st_misalign_o, bus.wr_en_o);
      end
    end
    send_store(AccHalf, 32'h3002, 32'hBEEF);
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0 || bus.st_misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL misalign_aligned_half: got left %0d misalign %b want 0 0", exp_q.size(), bus.st_misalign_o);
    end
  endtask

  task automatic test_load_priority();
    bus.wr_ready_i = 1'b0;
    send_store(AccWord, 32'h4000, 32'h1);
    send_store(AccWord, 32'h4004, 32'h2);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 32'h5000;
    bus.wr_ready_i = 1'b1;
    #1;
`ifdef STBUF_LOAD_PRIORITY_EN
    checks++;
    if (bus.wr_en_o !== 1'b0 || bus.ld_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold: got wr_en %b stall %b want 0 0", bus.wr_en_o, bus.ld_stall_o);
    end
    step();
    checks++;
    if (bus.wr_en_o !== 1'b0 || bus.empty_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold2: got wr_en %b empty %b want 0 0", bus.wr_en_o, bus.empty_o);
    end
    bus.ld_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b1) begin errors++; $display("FAIL prio_release: got %b want 1", bus.wr_en_o); end
`else
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.wr_en_o !== ((k % 2) == 0) || bus.ld_stall_o !== 1'b1) begin
        errors++;
        $display("FAIL eager_cycle%0d: got wr_en %b stall %b want %b 1", k, bus.wr_en_o,
                 bus.ld_stall_o, (k % 2) == 0);
      end
      step();
    end
    checks++;
    if (bus.ld_stall_o !== 1'b0 || bus.empty_o !== 1'b1) begin
      errors++;
      $display("FAIL eager_done: got stall %b empty %b want 0 1", bus.ld_stall_o, bus.empty_o);
    end
    bus.ld_valid_i = 1'b0;
`endif
    repeat (6) step();
    checks++;
    if (exp_q.size() != 0 || bus.empty_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_drained: got left %0d empty %b want 0 1", exp_q.size(), bus.empty_o);
    end
  endtask

  task automatic test_reset_mid_commit();
    bus.wr_ready_i = 1'b0;
    send_store(AccWord, 32'h6000, 32'h60);
    send_store(AccWord, 32'h6004, 32'h64);
    send_store(AccWord, 32'h6008, 32'h68);
    bus.wr_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got %b want 1", bus.wr_en_o); end
    step();
    rstn = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.empty_o !== 1'b1 || bus.wr_en_o !== 1'b0 || bus.st_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: got empty %b wr_en %b st_ready %b want 1 0 1",
               bus.empty_o, bus.wr_en_o, bus.st_ready_o);
    end
    step();
    rstn = 1'b1;
    repeat (5) step();
    checks++;
    if (bus.empty_o !== 1'b1 || bus.addr_w_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_after: got empty %b addr_w %h want 1 0", bus.empty_o, bus.addr_w_o);
    end
  endtask

  initial begin
    bus.st_valid_i = 1'b0;
    bus.st_acc_i   = AccByte;
    bus.st_addr_i  = '0;
    bus.st_data_i  = '0;
    bus.ld_valid_i = 1'b0;
    bus.ld_addr_i  = '0;
    bus.wr_ready_i = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_load_hazard();
    test_misalign();
    test_load_priority();
    test_reset_mid_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
